// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx
//   Read-side consumer for an 8-bit synchronous FIFO. When enabled and the
//   FIFO reports data, it pops one byte through the FIFO's registered read
//   port and sends it as a UART 8N1 frame on tx, LSB first. The block then
//   returns to IDLE and looks at the FIFO again.
//
//   Parameter
//     CLKS_PER_BIT  clk cycles per UART bit (legal values are 2 and above)
//
//   Ports
//     clk           system clock, rising edge
//     rst           synchronous, active-high reset
//     enable        permits new pops; looked at only in IDLE
//     fifo_isempty  FIFO empty flag (registered inside the FIFO)
//     fifo_dout     FIFO read data, valid the cycle after fifo_rd_en
//     fifo_rd_en    one-cycle pop request (FETCH state only)
//     tx            serial line, idles high
//     busy          high in every state except IDLE
//     tx_done       one-cycle pulse on the first IDLE cycle after a stop bit
//
//   Every output is decoded from registered state, counter and shift
//   register only, so no input reaches an output combinationally.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       fifo_isempty,
  input  logic [7:0] fifo_dout,
  output logic       fifo_rd_en,
  output logic       tx,
  output logic       busy,
  output logic       tx_done
);

  localparam int                CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    START = 3'd3,
    DATA  = 3'd4,
    STOP  = 3'd5
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             bit_end;
  logic             timed;

  // Last clock of the current bit period (START, DATA and STOP only).
  assign bit_end = (cnt == CNT_LAST);
  assign timed   = (state == START) || (state == DATA) || (state == STOP);

  // ---- state register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---- next-state logic ----
  // The empty flag lags the FIFO pointers by a cycle. It is only looked at
  // in IDLE, which is reached at least a full frame after the previous pop,
  // so a stale "not empty" can never trigger a read of an empty FIFO.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable && !fifo_isempty) state_nxt = FETCH;
      FETCH:   state_nxt = LOAD;
      LOAD:    state_nxt = START;
      START:   if (bit_end) state_nxt = DATA;
      DATA:    if (bit_end && (bit_idx == 3'd7)) state_nxt = STOP;
      STOP:    if (bit_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---- output decode ----
  always_comb begin
    tx         = 1'b1;
    busy       = 1'b1;
    fifo_rd_en = 1'b0;
    case (state)
      IDLE:    busy       = 1'b0;
      FETCH:   fifo_rd_en = 1'b1;
      START:   tx         = 1'b0;
      DATA:    tx         = shreg[0];
      default: tx         = 1'b1;
    endcase
  end

  // ---- baud counter, bit index and done pulse ----
  // The counter runs only in the timed states and clears at every bit
  // boundary; since each state change out of a timed state happens on a bit
  // boundary, this also clears it on every state change.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      bit_idx <= '0;
      tx_done <= 1'b0;
    end else begin
      tx_done <= (state == STOP) && bit_end;

      if (timed && !bit_end && (state_nxt == state)) begin
        cnt <= cnt + 1'b1;
      end else begin
        cnt <= '0;
      end

      if (state != DATA) begin
        bit_idx <= '0;
      end else if (bit_end && (bit_idx != 3'd7)) begin
        bit_idx <= bit_idx + 3'd1;
      end
    end
  end

  // ---- shift register ----
  // Pure datapath: it is always reloaded in LOAD before DATA reads it, so it
  // needs no reset.
  always_ff @(posedge clk) begin
    if (state == LOAD) begin
      shreg <= fifo_dout;
    end else if ((state == DATA) && bit_end) begin
      shreg <= {1'b0, shreg[7:1]};
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
module tb_fifo_uart_tx;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b1;
  logic       fifo_isempty = 1'b1;
  logic [7:0] fifo_dout = 8'h00;
  logic       fifo_rd_en;
  logic       tx;
  logic       busy;
  logic       tx_done;

  fifo_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .fifo_isempty (fifo_isempty),
    .fifo_dout    (fifo_dout),
    .fifo_rd_en   (fifo_rd_en),
    .tx           (tx),
    .busy         (busy),
    .tx_done      (tx_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // cycle counter: stable between rising edges
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic rst_q = 1'b1;
  always @(posedge clk) rst_q <= rst;

  // ---- 16-deep FIFO model with registered read port and lagging empty flag ----
  logic [7:0] fmem [16];
  logic [3:0] wptr = 4'd0;
  logic [3:0] rptr = 4'd0;
  int         fcount = 0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  bit         overflow = 1'b0;
  bit         underflow = 1'b0;
  int         rd_ok;
  int         wr_ok;

  always @(posedge clk) begin
    rd_ok = (fifo_rd_en === 1'b1 && fcount > 0) ? 1 : 0;
    wr_ok = (wr_en && fcount < 16) ? 1 : 0;
    if (fifo_rd_en === 1'b1 && fcount == 0) underflow <= 1'b1;
    if (wr_en && fcount == 16) overflow <= 1'b1;
    if (rd_ok == 1) begin
      fifo_dout <= fmem[rptr];
      rptr      <= rptr + 4'd1;
    end
    if (wr_ok == 1) begin
      fmem[wptr] <= wr_data;
      wptr       <= wptr + 4'd1;
    end
    fcount       <= fcount + wr_ok - rd_ok;
    fifo_isempty <= (fcount == 0);
  end

  // ---- scoreboard ----
  logic [7:0] exp_q [$];
  int         pop_cyc [$];
  int         pops = 0;
  int         dones = 0;
  int         frames = 0;
  int         aborts = 0;
  int         last_pop = 0;
  bit         mon_en = 1'b0;

  task automatic push_byte(input logic [7:0] b);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_data = b;
    exp_q.push_back(b);
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  // pop / done monitor
  always @(negedge clk) begin
    if (mon_en) begin
      if (fifo_rd_en === 1'b1) begin
        chk("rd_while_empty", fifo_isempty, 1'b0);
        chk("busy_fetch", busy, 1'b1);
        last_pop = cyc;
        pop_cyc.push_back(cyc);
        pops++;
      end
      if (tx_done === 1'b1) begin
        chk("done_latency", cyc, last_pop + 42);
        chk("busy_at_done", busy, 1'b0);
        dones++;
      end
    end
  end

  // frame receiver: samples every cycle of the 40-cycle frame
  logic       smp [40];
  logic [7:0] rx_b;
  bit         shape_ok;
  bit         aborted;
  int         st_cyc;

  initial begin : rx_mon
    forever begin
      @(negedge clk);
      if (mon_en && !rst_q && tx === 1'b0) begin
        st_cyc  = cyc;
        aborted = 1'b0;
        chk("start_latency", st_cyc, last_pop + 2);
        for (int k = 0; k < 40; k++) begin
          if (k > 0) @(negedge clk);
          if (rst_q) begin
            aborted = 1'b1;
            break;
          end
          smp[k] = tx;
        end
        if (aborted) begin
          aborts++;
          if (exp_q.size() > 0) void'(exp_q.pop_front());
        end else begin
          shape_ok = 1'b1;
          for (int j = 0; j < 10; j++)
            for (int q = 1; q < CPB; q++)
              if (smp[CPB*j+q] !== smp[CPB*j]) shape_ok = 1'b0;
          if (smp[0] !== 1'b0) shape_ok = 1'b0;
          if (smp[36] !== 1'b1) shape_ok = 1'b0;
          for (int i = 0; i < 8; i++) rx_b[i] = smp[CPB + CPB*i];
          chk("frame_shape", shape_ok, 1'b1);
          if (exp_q.size() == 0) chk("unexpected_frame", rx_b, 32'hFFFF_FFFF);
          else chk("rx_byte", rx_b, exp_q.pop_front());
          frames++;
        end
      end
    end
  end

  task automatic wait_dones(input string tag, input int target, input int budget);
    int n;
    n = 0;
    while (dones < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, (dones >= target), 1'b1);
  endtask

  task automatic wait_pop(input int p0, input int budget);
    int n;
    n = 0;
    while (pops == p0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("wait_pop", (pops > p0), 1'b1);
  endtask

  initial begin : main
    int idx;
    int p0;
    int d0;
    int c;

    // reset with the FIFO non-empty
    rst = 1'b1;
    push_byte(8'hA5);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_tx", tx, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_rd_en", fifo_rd_en, 1'b0);
      chk("rst_tx_done", tx_done, 1'b0);
    end
    chk("rst_no_pop", fcount, 1);
    rst    = 1'b0;
    mon_en = 1'b1;

    // single byte 0xA5
    wait_dones("wait_a5", 1, 200);

    // back-to-back frames
    idx = pop_cyc.size();
    push_byte(8'h01);
    push_byte(8'h80);
    push_byte(8'hFF);
    wait_dones("wait_b2b", 4, 400);
    chk("b2b_pops", pop_cyc.size() - idx, 3);
    if (pop_cyc.size() >= idx + 3) begin
      chk("b2b_gap1", pop_cyc[idx+1] - pop_cyc[idx], 43);
      chk("b2b_gap2", pop_cyc[idx+2] - pop_cyc[idx+1], 43);
    end
    repeat (3) @(negedge clk);
    chk("b2b_fifo_empty", fcount, 0);

    // pointer wrap: 20 bytes, slow enough never to fill
    for (int i = 0; i < 20; i++) begin
      push_byte(8'(i));
      repeat (28) @(negedge clk);
    end
    wait_dones("wait_wrap", 24, 1500);
    chk("wrap_overflow", overflow, 1'b0);

    // enable dropped mid-frame
    p0 = pops;
    d0 = dones;
    push_byte(8'h3C);
    push_byte(8'h11);
    push_byte(8'h22);
    wait_pop(p0, 100);
    repeat (12) @(negedge clk);
    enable = 1'b0;
    wait_dones("wait_3c", d0 + 1, 200);
    repeat (60) @(negedge clk);
    chk("dis_no_pop", pops, p0 + 1);
    chk("dis_fifo_held", fcount, 2);
    chk("dis_busy", busy, 1'b0);
    enable = 1'b1;
    c = cyc;
    wait_pop(p0 + 1, 10);
    chk("reenable_latency", last_pop, c + 1);
    wait_dones("wait_en_rest", d0 + 3, 300);

    // reset during DATA bit 4
    p0 = pops;
    d0 = dones;
    push_byte(8'h5A);
    push_byte(8'hC3);
    wait_pop(p0, 100);
    while (cyc < last_pop + 23) @(negedge clk);
    chk("pre_rst_busy", busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_tx", tx, 1'b1);
    chk("midrst_busy", busy, 1'b0);
    rst = 1'b0;
    wait_dones("wait_after_rst", d0 + 1, 300);
    repeat (5) @(negedge clk);

    // final bookkeeping
    chk("aborts", aborts, 1);
    chk("frames_total", frames, 28);
    chk("pops_total", pops, 29);
    chk("dones_vs_frames", dones, frames);
    chk("exp_q_empty", exp_q.size(), 0);
    chk("fifo_end_count", fcount, 0);
    chk("fifo_end_empty", fifo_isempty, 1'b1);
    chk("underflow", underflow, 1'b0);
    chk("overflow", overflow, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #500000;
    n_checks++;
    n_fail++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
